// File: rtl/audio_sample_packet_decoder.sv
// Sink-side HDMI audio sample packet decoder (2-channel layout 0): unpacks
// subpackets, checks IEC 60958 parity, tracks the 192-frame channel-status
// block and delivers L/R pairs through a first-word-fall-through FIFO.
module audio_sample_packet_decoder #(
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter bit          CHECK_PARITY = 1'b1
) (
   input  logic        clk_pixel,
   input  logic        reset_n,
   input  logic        packet_valid,
   input  logic [23:0] header,
   input  logic [55:0] sub [4],
   output logic        sample_valid,
   input  logic        sample_ready,
   output logic [23:0] audio_sample_word [2],
   output logic [1:0]  sample_parity_error,
   output logic        sample_block_start,
   output logic [39:0] channel_status_left,
   output logic [39:0] channel_status_right,
   output logic        channel_status_valid,
   output logic        block_sync,
   output logic        packet_dropped,
   output logic        sync_error,
   output logic        overflow
);
   localparam int unsigned AW         = $clog2(FIFO_DEPTH);
   localparam int unsigned PW         = AW + 1;
   localparam int unsigned FW         = 8;
   localparam int unsigned CSW        = 40;
   localparam int unsigned LAST_FRAME = 191;

   typedef enum logic {IDLE, UNPACK} state_t;

   typedef struct packed {
      logic        block_start;
      logic [1:0]  err;
      logic [23:0] right;
      logic [23:0] left;
   } entry_t;

   state_t         state, state_n;
   logic [1:0]     idx, idx_n;
   logic [3:0]     present_buf, bflag_buf;
   logic [55:0]    sub_buf [4];
   logic [55:0]    cur_c;
   logic           present_c, bflag_c, is_audio_c, capture_c, push_c, pop_c;
   logic           full_c, empty_c;
   entry_t         entry_c, head_c;
   entry_t         mem [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [FW-1:0]  frame, frame_n;
   logic           sync_n, sync_err_c, cs_done_c;
   logic [CSW-1:0] cs_l, cs_r, cs_l_n, cs_r_n;
   logic           unused_hdr;

   assign unused_hdr  = ^header[19:13];
   assign is_audio_c  = (header[7:0] == 8'd2) && !header[12];
   assign cur_c       = sub_buf[idx];
   assign present_c   = present_buf[idx];
   assign bflag_c     = bflag_buf[idx];
   assign empty_c     = (wr_ptr == rd_ptr);
   assign full_c      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign sample_valid = !empty_c;
   assign pop_c       = sample_valid && sample_ready;
   assign head_c      = mem[rd_ptr[AW-1:0]];

   // Next-state: capture in IDLE, walk subpackets in UNPACK, stall on a full FIFO
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      capture_c = 1'b0;
      push_c    = 1'b0;
      case (state)
         IDLE: begin
            if (packet_valid && is_audio_c) begin
               capture_c = 1'b1;
               idx_n     = 2'd0;
               state_n   = UNPACK;
            end
         end
         UNPACK: begin
            if (!present_c || !full_c || pop_c) begin
               push_c = present_c;
               idx_n  = idx + 2'd1;
               if (idx == 2'd3) state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // FIFO entry for the current subpacket, including parity check
   always_comb begin
      entry_c             = '0;
      entry_c.left        = cur_c[23:0];
      entry_c.right       = cur_c[47:24];
      entry_c.block_start = bflag_c;
      if (CHECK_PARITY) begin
         entry_c.err[0] = cur_c[51] ^ (^{cur_c[50:48], cur_c[23:0]});
         entry_c.err[1] = cur_c[55] ^ (^{cur_c[54:52], cur_c[47:24]});
      end
   end

   // Frame counter, block lock and channel-status capture per written sample
   always_comb begin
      frame_n    = frame;
      sync_n     = block_sync;
      sync_err_c = 1'b0;
      cs_done_c  = 1'b0;
      cs_l_n     = cs_l;
      cs_r_n     = cs_r;
      if (push_c) begin
         if (bflag_c) begin
            if (block_sync && (frame != FW'(LAST_FRAME))) sync_err_c = 1'b1;
            frame_n = '0;
            sync_n  = 1'b1;
         end else begin
            if (frame == FW'(LAST_FRAME)) begin
               sync_err_c = 1'b1;
               sync_n     = 1'b0;
            end
            frame_n = frame + FW'(1);
         end
         if (sync_n && (frame_n < FW'(CSW))) begin
            cs_l_n[frame_n[5:0]] = cur_c[50];
            cs_r_n[frame_n[5:0]] = cur_c[54];
         end
         if (sync_n && (frame_n == FW'(LAST_FRAME))) cs_done_c = 1'b1;
      end
   end

   // Control and status registers
   always_ff @(posedge clk_pixel) begin
      if (!reset_n) begin
         state                <= IDLE;
         idx                  <= '0;
         present_buf          <= '0;
         bflag_buf            <= '0;
         wr_ptr               <= '0;
         rd_ptr               <= '0;
         frame                <= '0;
         block_sync           <= 1'b0;
         cs_l                 <= '0;
         cs_r                 <= '0;
         channel_status_left  <= '0;
         channel_status_right <= '0;
         channel_status_valid <= 1'b0;
         sync_error           <= 1'b0;
         packet_dropped       <= 1'b0;
         overflow             <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         if (capture_c) begin
            present_buf <= header[11:8];
            bflag_buf   <= header[23:20];
         end
         if (push_c) wr_ptr <= wr_ptr + PW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
         frame      <= frame_n;
         block_sync <= sync_n;
         cs_l       <= cs_l_n;
         cs_r       <= cs_r_n;
         channel_status_valid <= cs_done_c;
         if (cs_done_c) begin
            channel_status_left  <= cs_l_n;
            channel_status_right <= cs_r_n;
         end
         sync_error     <= sync_err_c;
         packet_dropped <= (state == UNPACK) && packet_valid && is_audio_c;
         if (push_c && full_c && !pop_c) overflow <= 1'b1;
      end
   end

   // Packet buffer and FIFO storage (no reset needed: guarded by state and pointers)
   always_ff @(posedge clk_pixel) begin
      if (reset_n && capture_c) begin
         for (int i = 0; i < 4; i++) sub_buf[i] <= sub[i];
      end
      if (reset_n && push_c) mem[wr_ptr[AW-1:0]] <= entry_c;
   end

   // FIFO head presented only while valid so outputs read 0 when empty
   always_comb begin
      audio_sample_word[0] = '0;
      audio_sample_word[1] = '0;
      sample_parity_error  = '0;
      sample_block_start   = 1'b0;
      if (sample_valid) begin
         audio_sample_word[0] = head_c.left;
         audio_sample_word[1] = head_c.right;
         sample_parity_error  = head_c.err;
         sample_block_start   = head_c.block_start;
      end
   end
endmodule

// File: tb/tb_audio_sample_packet_decoder.sv
// Scoreboard bench for audio_sample_packet_decoder with a behavioural model.
module tb_audio_sample_packet_decoder;
   logic        clk_pixel = 1'b0;
   logic        reset_n;
   logic        packet_valid;
   logic [23:0] header;
   logic [55:0] sub [4];
   logic        sample_valid;
   logic        sample_ready;
   logic [23:0] audio_sample_word [2];
   logic [1:0]  sample_parity_error;
   logic        sample_block_start;
   logic [39:0] channel_status_left;
   logic [39:0] channel_status_right;
   logic        channel_status_valid;
   logic        block_sync;
   logic        packet_dropped;
   logic        sync_error;
   logic        overflow;

   always #5 clk_pixel = ~clk_pixel;

   audio_sample_packet_decoder #(.FIFO_DEPTH(8), .CHECK_PARITY(1'b1)) dut (
      .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_valid(packet_valid),
      .header(header), .sub(sub), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .audio_sample_word(audio_sample_word),
      .sample_parity_error(sample_parity_error), .sample_block_start(sample_block_start),
      .channel_status_left(channel_status_left), .channel_status_right(channel_status_right),
      .channel_status_valid(channel_status_valid), .block_sync(block_sync),
      .packet_dropped(packet_dropped), .sync_error(sync_error), .overflow(overflow)
   );

   int total = 0;
   int bad   = 0;
   logic [50:0] exp_q [$];
   logic [79:0] cs_q [$];
   bit          sb_q [$];
   bit          sc_q [$];
   int sync_seen = 0, cs_seen = 0, drop_seen = 0;
   int exp_sync = 0, exp_cs = 0, exp_drop = 0;
   int m_frame = 0;
   bit m_sync = 1'b0;
   logic [39:0] m_csl = '0, m_csr = '0;
   bit rand_ready = 1'b0;
   logic [39:0] cs_pat = 40'hA5_5A_F0_0F_33;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted sample and counts pulses
   always @(negedge clk_pixel) begin
      if (reset_n) begin
         if (sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_sample: got %h expected none", audio_sample_word[0]);
            end else begin
               check("sample", 96'({sample_block_start, sample_parity_error,
                                    audio_sample_word[1], audio_sample_word[0]}),
                     96'(exp_q.pop_front()));
            end
         end
         if (channel_status_valid) begin
            cs_seen++;
            if (cs_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_cs_pulse: got %h expected none", channel_status_left);
            end else begin
               check("channel_status", 96'({channel_status_right, channel_status_left}),
                     96'(cs_q.pop_front()));
            end
         end
         if (sync_error)     sync_seen++;
         if (packet_dropped) drop_seen++;
      end
   end

   task automatic tick();
      @(posedge clk_pixel);
      #1;
      if (rand_ready) sample_ready = 1'($urandom);
   endtask

   // Reference model: IEC 60958 block tracking for one present sample
   task automatic model_sample(input bit b, input bit cl, input bit cr);
      if (b) begin
         if (m_sync && m_frame != 191) exp_sync++;
         m_frame = 0;
         m_sync  = 1'b1;
      end else begin
         if (m_frame == 191) begin
            exp_sync++;
            m_sync = 1'b0;
         end
         m_frame = m_frame + 1;
      end
      if (m_sync && m_frame < 40) begin
         m_csl[m_frame] = cl;
         m_csr[m_frame] = cr;
      end
      if (m_sync && m_frame == 191) begin
         cs_q.push_back({m_csr, m_csl});
         exp_cs++;
      end
   endtask

   task automatic send_audio(input logic [3:0] pres, input logic [3:0] bf_in, input logic [3:0] cl,
                             input logic [3:0] bad_l, input logic [3:0] bad_r,
                             input bit fixed, input bit accept, input bit auto_b);
      logic [23:0] l, r;
      logic vl, ul, vr, ur, cr, pl, pr;
      logic [3:0] bf;
      bf = bf_in;
      for (int i = 0; i < 4; i++) begin
         l  = fixed ? 24'h123456 : 24'($urandom);
         r  = fixed ? 24'hABCDEF : 24'($urandom);
         vl = 1'($urandom); ul = 1'($urandom);
         vr = 1'($urandom); ur = 1'($urandom); cr = 1'($urandom);
         if (auto_b) bf[i] = (m_frame >= 150) || ($urandom_range(0, 31) == 0);
         pl = (^{cl[i], ul, vl, l}) ^ bad_l[i];
         pr = (^{cr, ur, vr, r}) ^ bad_r[i];
         sub[i] = {pr, cr, ur, vr, pl, cl[i], ul, vl, r, l};
         if (accept && pres[i]) begin
            exp_q.push_back({bf[i], bad_r[i], bad_l[i], r, l});
            model_sample(bf[i], cl[i], cr);
         end
      end
      if (!accept) exp_drop++;
      header = {bf, 7'($urandom), 1'b0, pres, 8'd2};
      packet_valid = 1'b1;
      tick();
      packet_valid = 1'b0;
   endtask

   // Non-audio traffic that the decoder must ignore silently
   task automatic junk_tick();
      if ($urandom_range(0, 2) == 0) begin
         header = 24'($urandom);
         if (header[7:0] == 8'd2) header[12] = 1'b1;
         for (int i = 0; i < 4; i++) sub[i] = {24'($urandom), 32'($urandom)};
         packet_valid = 1'b1;
      end
      tick();
      packet_valid = 1'b0;
   endtask

   task automatic flush_stream();
      logic [3:0] bf, cl;
      while (sb_q.size() > 0) begin
         for (int i = 0; i < 4; i++) begin
            bf[i] = (sb_q.size() > 0) ? sb_q.pop_front() : 1'b0;
            cl[i] = (sc_q.size() > 0) ? sc_q.pop_front() : 1'($urandom);
         end
         send_audio(4'hF, bf, cl, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
         repeat (4) tick();
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         tick();
         n++;
      end
      check(name, 96'(exp_q.size()), 96'(0));
      repeat (3) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, c0, d0;
      reset_n      = 1'b0;
      packet_valid = 1'b1;
      header       = {4'hF, 7'd0, 1'b0, 4'hF, 8'd2};
      for (int i = 0; i < 4; i++) sub[i] = {24'($urandom), 32'($urandom)};
      sample_ready = 1'b1;

      // Reset with a valid packet strobe held high
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_pixel);
         check("reset_outputs", 96'({sample_valid, audio_sample_word[0], audio_sample_word[1],
                                     sample_parity_error, sample_block_start, channel_status_valid,
                                     block_sync, packet_dropped, sync_error, overflow}), 96'(0));
         check("reset_cs", 96'({channel_status_left, channel_status_right}), 96'(0));
      end
      @(posedge clk_pixel); #1;
      packet_valid = 1'b0;
      reset_n      = 1'b1;
      repeat (3) tick();

      // Single packet, subpackets 0 and 2 present, fixed words, good parity
      send_audio(4'b0101, 4'b0000, 4'($urandom), 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
      check("latency_before", 96'(sample_valid), 96'(0));
      tick();
      check("latency_after", 96'(sample_valid), 96'(1));
      repeat (3) tick();
      wait_drain("drain_single");

      // Right-channel parity flipped in subpacket 1
      send_audio(4'hF, 4'h0, 4'($urandom), 4'h0, 4'b0010, 1'b0, 1'b1, 1'b0);
      repeat (4) tick();
      wait_drain("drain_parity");

      // Full 192-frame block with known left channel status
      s0 = sync_seen; c0 = cs_seen;
      for (int k = 0; k < 192; k++) begin
         sb_q.push_back(k == 0);
         sc_q.push_back((k < 40) ? cs_pat[k] : 1'($urandom));
      end
      flush_stream();
      wait_drain("drain_block");
      check("block_cs_pulses", 96'(cs_seen - c0), 96'(1));
      check("block_cs_left", 96'(channel_status_left), 96'(40'hA5_5A_F0_0F_33));
      check("block_sync_set", 96'(block_sync), 96'(1));
      check("block_no_sync_err", 96'(sync_seen - s0), 96'(0));

      // Early B at frame 100, then a missing B at frame 192
      s0 = sync_seen; c0 = cs_seen;
      sb_q.push_back(1'b1);
      for (int k = 0; k < 99; k++)  sb_q.push_back(1'b0);
      sb_q.push_back(1'b1);
      for (int k = 0; k < 195; k++) sb_q.push_back(1'b0);
      flush_stream();
      wait_drain("drain_sync");
      check("sync_err_pulses", 96'(sync_seen - s0), 96'(2));
      check("sync_lost", 96'(block_sync), 96'(0));
      check("sync_cs_pulses", 96'(cs_seen - c0), 96'(1));

      // Fill the FIFO with ready low, stall, and drop a packet during the stall
      d0 = drop_seen;
      sample_ready = 1'b0;
      send_audio(4'hF, 4'h0, 4'($urandom), 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      repeat (4) tick();
      send_audio(4'hF, 4'h0, 4'($urandom), 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      repeat (4) tick();
      send_audio(4'hF, 4'h0, 4'($urandom), 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      send_audio(4'hF, 4'h0, 4'($urandom), 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      check("stall_drop_pulse", 96'(drop_seen - d0), 96'(1));
      check("stall_no_overflow", 96'(overflow), 96'(0));
      check("stall_head_valid", 96'(sample_valid), 96'(1));
      sample_ready = 1'b1;
      wait_drain("drain_stall");

      // Randomized traffic with random back-pressure and ignored non-audio packets
      rand_ready = 1'b1;
      for (int p = 0; p < 60; p++) begin
         int n = 0;
         while (exp_q.size() > 4 && n < 500) begin
            tick();
            n++;
         end
         if (n >= 500) check("random_space_timeout", 96'(exp_q.size()), 96'(4));
         send_audio(4'($urandom), 4'h0, 4'($urandom), 4'($urandom) & 4'($urandom),
                    4'($urandom) & 4'($urandom), 1'b0, 1'b1, 1'b1);
         repeat (4) junk_tick();
      end
      rand_ready   = 1'b0;
      sample_ready = 1'b1;
      wait_drain("drain_random");

      check("final_sync_errors", 96'(sync_seen), 96'(exp_sync));
      check("final_cs_pulses", 96'(cs_seen), 96'(exp_cs));
      check("final_drops", 96'(drop_seen), 96'(exp_drop));
      check("final_block_sync", 96'(block_sync), 96'(m_sync));
      check("final_overflow", 96'(overflow), 96'(0));
      check("final_cs_queue", 96'(cs_q.size()), 96'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
